// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit owning the HI/LO register pair.
// Operands are latched at acceptance and the result commits when the busy counter expires.
module mdu_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        Start,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept_s;
  logic [63:0] smul_s;
  logic [63:0] umul_s;
  logic [31:0] a_mag_s, b_mag_s;
  logic [31:0] q_mag_s, r_mag_s;
  logic [31:0] sdiv_q_s, sdiv_r_s;
  logic [31:0] udiv_q_s, udiv_r_s;
  logic        res_valid_s;
  logic [31:0] res_hi_s, res_lo_s;

  assign accept_s = Start && !Req && (cnt_q == 4'd0) &&
                    ((MDUOp == OP_MULT) || (MDUOp == OP_MULTU) ||
                     (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU));

  // Signed division works on magnitudes so the most-negative / -1 case needs no special path.
  always_comb begin
    smul_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    umul_s  = {32'd0, a_q} * {32'd0, b_q};
    a_mag_s = a_q[31] ? (32'd0 - a_q) : a_q;
    b_mag_s = b_q[31] ? (32'd0 - b_q) : b_q;
    if (b_q != 32'd0) begin
      q_mag_s  = a_mag_s / b_mag_s;
      r_mag_s  = a_mag_s % b_mag_s;
      udiv_q_s = a_q / b_q;
      udiv_r_s = a_q % b_q;
    end else begin
      q_mag_s  = 32'd0;
      r_mag_s  = 32'd0;
      udiv_q_s = 32'd0;
      udiv_r_s = 32'd0;
    end
    sdiv_q_s = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag_s) : q_mag_s;
    sdiv_r_s = a_q[31] ? (32'd0 - r_mag_s) : r_mag_s;
  end

  always_comb begin
    res_valid_s = 1'b0;
    res_hi_s    = hi_q;
    res_lo_s    = lo_q;
    case (op_q)
      OP_MULT: begin
        res_valid_s = 1'b1;
        {res_hi_s, res_lo_s} = smul_s;
      end
      OP_MULTU: begin
        res_valid_s = 1'b1;
        {res_hi_s, res_lo_s} = umul_s;
      end
      OP_DIV: begin
        res_valid_s = (b_q != 32'd0);
        res_hi_s    = sdiv_r_s;
        res_lo_s    = sdiv_q_s;
      end
      OP_DIVU: begin
        res_valid_s = (b_q != 32'd0);
        res_hi_s    = udiv_r_s;
        res_lo_s    = udiv_q_s;
      end
      default: begin
        res_valid_s = 1'b0;
      end
    endcase
  end

  // A running operation owns HI/LO; moves and new starts only apply while idle.
  always_comb begin
    cnt_d = cnt_q;
    op_d  = op_q;
    a_d   = a_q;
    b_d   = b_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      if ((cnt_q == 4'd1) && res_valid_s) begin
        hi_d = res_hi_s;
        lo_d = res_lo_s;
      end else begin
        hi_d = hi_q;
      end
    end else if (accept_s) begin
      op_d  = MDUOp;
      a_d   = A;
      b_d   = B;
      cnt_d = ((MDUOp == OP_DIV) || (MDUOp == OP_DIVU)) ? DIV_CYCLES : MULT_CYCLES;
    end else if (!Req && (MDUOp == OP_MTHI)) begin
      hi_d = A;
    end else if (!Req && (MDUOp == OP_MTLO)) begin
      lo_d = A;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
      op_q  <= 4'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      op_q  <= op_d;
      a_q   <= a_d;
      b_q   <= b_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign Busy = (cnt_q != 4'd0);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    case (MDUOp)
      OP_MFHI: MDU_out = hi_q;
      OP_MFLO: MDU_out = lo_q;
      default: MDU_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed and randomized checks of mdu_unit against a 64-bit
// arithmetic reference model with transaction-level timing expectations.
module tb_mdu_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  MDUOp;
  logic        Start;
  logic        Req;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDU_out;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] exp_hi   = 32'd0;
  logic [31:0] exp_lo   = 32'd0;

  always #5 clk = ~clk;

  mdu_unit dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .Start(Start), .Req(Req),
    .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO), .MDU_out(MDU_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    Start = 1'b0;
    MDUOp = 4'd0;
    Req   = 1'b0;
  endtask

  // Reference: plain 64-bit arithmetic; divide by zero leaves HI/LO alone.
  function automatic void ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                    inout logic [31:0] hi, inout logic [31:0] lo);
    longint      sa, sb, sq, sr, sp;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd1: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      4'd2: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
      4'd3: if (b != 32'd0) begin sq = sa / sb; sr = sa % sb; hi = sr[31:0]; lo = sq[31:0]; end
      4'd4: if (b != 32'd0) begin hi = a % b; lo = a / b; end
      default: ;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit req_mid);
    int busy_cnt;
    int want;
    MDUOp = op; A = a; B = b; Start = 1'b1; Req = 1'b0;
    cyc();
    ref_model(op, a, b, exp_hi, exp_lo);
    want = (op == 4'd3 || op == 4'd4) ? 10 : 5;
    busy_cnt = 0;
    while (Busy && busy_cnt < 20) begin
      busy_cnt++;
      Start = 1'b0;
      if (disturb) begin
        A = $urandom; B = $urandom;
        MDUOp = 4'($urandom_range(0, 15));
        Start = (busy_cnt == 2);
        if (busy_cnt == 2) MDUOp = 4'd3;
      end
      Req = req_mid ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc();
    end
    idle();
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(want));
    check_regs(tag);
    MDUOp = 4'd5; #1;
    check({tag, "_mfhi"}, MDU_out, exp_hi);
    MDUOp = 4'd6; #1;
    check({tag, "_mflo"}, MDU_out, exp_lo);
    MDUOp = 4'd0; #1;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] val, input bit req);
    MDUOp = op; A = val; Req = req; Start = 1'b0;
    cyc();
    idle();
    if (!req && op == 4'd7) exp_hi = val;
    if (!req && op == 4'd8) exp_lo = val;
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    idle();
    A = 32'd0; B = 32'd0;
    reset = 1'b1;
    cyc(); cyc();
    check("rst_busy", 32'(Busy), 32'd0);
    check_regs("rst");
    MDUOp = 4'd5; #1;
    check("rst_mfhi", MDU_out, 32'd0);
    MDUOp = 4'd0;
    reset = 1'b0;

    run_op("mult_neg2x3", 4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    check("mult_hi_const", HI, 32'hFFFFFFFF);
    check("mult_lo_const", LO, 32'hFFFFFFFA);

    run_op("div_m7_2", 4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check("div_lo_const", LO, 32'hFFFFFFFD);
    check("div_hi_const", HI, 32'hFFFFFFFF);
    run_op("divu_m7_2", 4'd4, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check("divu_lo_const", LO, 32'h7FFFFFFC);
    check("divu_hi_const", HI, 32'h00000001);

    run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    check("ovf_lo_const", LO, 32'h80000000);
    check("ovf_hi_const", HI, 32'h00000000);

    mt(4'd7, 32'h1234, 1'b0);
    mt(4'd8, 32'h5678, 1'b0);
    check_regs("mt_preset");
    run_op("div_by0", 4'd3, 32'd99, 32'd0, 1'b0, 1'b0);
    check("div0_hi_const", HI, 32'h1234);
    check("div0_lo_const", LO, 32'h5678);

    run_op("multu_stale", 4'd2, 32'hDEADBEEF, 32'h12345679, 1'b1, 1'b0);
    check("stale_idle_after", 32'(Busy), 32'd0);

    MDUOp = 4'd1; A = 32'd7; B = 32'd9; Start = 1'b1; Req = 1'b1;
    cyc();
    idle();
    check("req_start_busy", 32'(Busy), 32'd0);
    check_regs("req_start");
    mt(4'd8, 32'hAAAA, 1'b1);
    check_regs("req_mtlo");
    run_op("req_mid_mult", 4'd1, 32'h7FFFFFFF, 32'h80000001, 1'b0, 1'b1);

    MDUOp = 4'd3; A = 32'd1000; B = 32'd7; Start = 1'b1;
    cyc();
    idle();
    cyc(); cyc(); cyc();
    check("pre_rst_busy", 32'(Busy), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0;
    check("rst_mid_busy", 32'(Busy), 32'd0);
    check_regs("rst_mid");
    run_op("mult_after_rst", 4'd1, 32'hFFFFF000, 32'h00012345, 1'b0, 1'b0);
    repeat (12) cyc();
    check_regs("no_late_wb");

    for (int i = 0; i < 30; i++) begin
      rop = 4'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: ra = 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        3: rb = 32'($urandom_range(1, 16));
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0) mt(4'($urandom_range(7, 8)), $urandom, 1'($urandom_range(0, 1)));
      run_op("rand", rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 MDUOp  input  4  E-stage op code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9-15 treated as none.
REQ-004 Start  input  1  E-stage instruction is mult/multu/div/divu and is valid this cycle.
REQ-005 Req  input  1  exception/interrupt flush this cycle; blocks any new MDU side effect.
REQ-006 A  input  32  rs operand (forwarded).
REQ-007 B  input  32  rt operand (forwarded).
REQ-008 Busy  output  1  multi-cycle operation in progress.
REQ-009 HI  output  32  HI register.
REQ-010 LO  output  32  LO register.
REQ-011 MDU_out  output  32  mfhi/mflo read data to E-stage result mux.

Function
REQ-012 Start is accepted on a rising edge only when Start=1, MDUOp is in 1..4, Busy=0 and Req=0.
REQ-013 On acceptance, the unit latches A, B and MDUOp internally. It loads the cycle counter with 5 for mult/multu and 10 for div/divu.
REQ-014 Busy = (counter != 0); Busy rises on the edge that accepts Start and stays high for exactly 5 (mult) or 10 (div) cycles.
REQ-015 Each edge with counter != 0 decrements the counter. The edge taking counter 1->0 writes the latched result to HI/LO, and Busy falls on that same edge.
REQ-016 mult: {HI,LO} = signed 64-bit A*B. multu: {HI,LO} = unsigned 64-bit A*B.
REQ-017 div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-018 Signed overflow case 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
REQ-019 divu: LO = unsigned quotient, HI = unsigned remainder.
REQ-020 Divide by zero (B=0, div or divu): the op runs its full 10 cycles, and HI and LO are left unchanged at completion.
REQ-021 Results are computed from the operands latched at acceptance; changes on A/B/MDUOp during Busy have no effect.
REQ-022 mthi (7): HI <= A on the edge, only when Busy=0 and Req=0. mtlo (8) does the same for LO.
REQ-023 mthi/mtlo while Busy=1 is ignored; the hazard unit stalls the pipeline, so this case is defensive only.
REQ-024 Start while Busy=1 is ignored; the current operation continues unaffected.
REQ-025 Req=1 during Busy does not abort the running operation; it completes and writes HI/LO normally.
REQ-026 Req=1 on the same edge as Start or mthi/mtlo suppresses that operation entirely: no latch, no counter load, no HI/LO write.
REQ-027 MDU_out is combinational: HI when MDUOp=5, LO when MDUOp=6, else 0x00000000.
REQ-028 MDU_out reflects the HI/LO register state, with no bypass of an in-flight result.
REQ-029 HI and LO change only at completion (REQ-015), mthi/mtlo (REQ-022) or reset; no other event alters them.

Reset
REQ-030 When reset=1 at an edge: HI=0, LO=0, counter=0, Busy=0, latched operands/op cleared; takes priority over every other input.
REQ-031 Reset during Busy aborts the operation with no HI/LO writeback; Busy=0 from the next cycle.
REQ-032 After reset, the unit accepts Start on the first edge at which reset=0.

Verification
REQ-033 Mult: Start=1, MDUOp=1, A=0xFFFFFFFE (-2), B=3 for one cycle.
- Response: Busy=1 for exactly 5 cycles.
- On the falling edge of Busy: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- Then MDUOp=6 gives MDU_out=0xFFFFFFFA.
REQ-034 Signed div: MDUOp=3, A=0xFFFFFFF9 (-7), B=2.
- Response: Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Repeat with divu on the same operands: LO=0x7FFFFFFC, HI=0x00000001.
REQ-035 Divide by zero: HI=0x1234, LO=0x5678 preset via mthi/mtlo, then div with B=0.
- Response: Busy for 10 cycles; HI=0x1234, LO=0x5678 unchanged.
REQ-036 Stale-operand and double-start check: during a multu, change A/B every cycle and pulse Start with a new op at cycle 2.
- Response: result uses the original operands; the second Start is ignored; Busy stays exactly 5 cycles.
REQ-037 Req gating:
- Req=1 together with Start: no Busy, HI/LO unchanged.
- Req=1 together with mtlo A=0xAAAA: LO unchanged.
- Req=1 mid-mult: result still written at completion.
REQ-038 Reset mid-div at cycle 4 of Busy.
- Response: next cycle Busy=0, HI=LO=0, and no later writeback occurs.
- A new mult accepted immediately afterward completes correctly.
